// File: rtl/hazard_scheduler.sv
// Decode-stage hazard controller: scoreboard of in-flight writes, issue/stall/flush decisions, stall counter.
// Latency: stall/bubble/flush are combinational from the scoreboard, FSM state and decode inputs in the same cycle.
// Backpressure: stall freezes PC and IF/ID until the producer leaves the hazard window; flush has priority over stall.
// Optional feature macro: HAZARD_FORWARDING_EN (adds fwd_sel1/fwd_sel2, stalls only on load-use).
module hazard_scheduler #(
    parameter int DEPTH        = 3,
    parameter bit WB_BYPASS    = 1'b1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  src1,
    input  logic [4:0]  src2,
    input  logic        src2_used,
    input  logic [4:0]  id_dest,
    input  logic        id_wb_en,
    input  logic        id_mem_r_en,
    input  logic        br_taken,
    output logic        stall,
    output logic        bubble,
    output logic        flush,
`ifdef HAZARD_FORWARDING_EN
    output logic [1:0]  fwd_sel1,
    output logic [1:0]  fwd_sel2,
`endif
    output logic [15:0] stall_cnt
);

    typedef struct packed {
        logic       v;
        logic [4:0] dest;
        logic       ld;
    } slot_t;

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    localparam logic [3:0] CNT_RELOAD = 4'(FLUSH_CYCLES - 1);

    slot_t       slot_q [DEPTH];
    slot_t       slot_d [DEPTH];
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic [DEPTH-1:0] match1, match2;
    logic             hazard;
    logic             issue;

    // Per-slot source matches; the WB slot is invisible when the register file bypasses writes to reads.
    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match1[i] = (src1 != 5'd0) && slot_q[i].v && (slot_q[i].dest == src1) &&
                        ((i < DEPTH - 1) || !WB_BYPASS);
            match2[i] = (src2 != 5'd0) && slot_q[i].v && (slot_q[i].dest == src2) &&
                        ((i < DEPTH - 1) || !WB_BYPASS);
        end
    end

`ifdef HAZARD_FORWARDING_EN
    // With forwarding only a load still in EXE blocks its consumer, for exactly one cycle.
    always_comb begin
        hazard = id_valid && slot_q[0].v && slot_q[0].ld &&
                 (match1[0] || (src2_used && match2[0]));
    end

    // Forward source select: youngest matching slot wins (EXE=1, MEM=2), else register file.
    always_comb begin
        fwd_sel1 = 2'd0;
        fwd_sel2 = 2'd0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i < 2 && match1[i]) begin
                fwd_sel1 = 2'(i + 1);
            end
            if (i < 2 && src2_used && match2[i]) begin
                fwd_sel2 = 2'(i + 1);
            end
        end
    end
`else
    // Full scoreboard interlock: any pending write to a read source blocks issue.
    always_comb begin
        hazard = id_valid && ((|match1) || (src2_used && (|match2)));
    end

    // The load flag only matters when forwarding; fold it into a sink so it is visibly intentional.
    logic unused_ld;
    always_comb begin
        unused_ld = id_mem_r_en;
        for (int i = 0; i < DEPTH; i++) begin
            unused_ld = unused_ld ^ slot_q[i].ld;
        end
    end
`endif

    // Control outputs; everything reads quiet while reset is held regardless of br_taken.
    always_comb begin
        flush  = !rst && (br_taken || (state_q == S_FLUSH));
        stall  = !rst && hazard && !flush;
        bubble = stall || flush;
        issue  = id_valid && !stall && !flush;
    end

    // Scoreboard shift: a stalled or flushed instruction enters EXE as an empty slot.
    always_comb begin
        slot_d[0] = '{v: issue && id_wb_en && (id_dest != 5'd0), dest: id_dest, ld: id_mem_r_en};
        for (int i = 1; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i-1];
        end
    end

    // Flush window: br_taken starts (or restarts) a window of FLUSH_CYCLES cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (br_taken && FLUSH_CYCLES > 1) begin
                    state_d = S_FLUSH;
                    cnt_d   = CNT_RELOAD;
                end
            end
            S_FLUSH: begin
                if (br_taken) begin
                    cnt_d = CNT_RELOAD;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Saturating stall-cycle counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            state_q     <= S_RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Forwarding scenarios run when HAZARD_FORWARDING_EN is defined, interlock scenarios otherwise.
module tb_hazard_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  src1, src2, id_dest;
    logic        src2_used, id_wb_en, id_mem_r_en, br_taken;
    logic        stall, bubble, flush;
    logic [15:0] stall_cnt;
`ifdef HAZARD_FORWARDING_EN
    logic [1:0]  fwd_sel1, fwd_sel2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .src1       (src1),
        .src2       (src2),
        .src2_used  (src2_used),
        .id_dest    (id_dest),
        .id_wb_en   (id_wb_en),
        .id_mem_r_en(id_mem_r_en),
        .br_taken   (br_taken),
        .stall      (stall),
        .bubble     (bubble),
        .flush      (flush),
`ifdef HAZARD_FORWARDING_EN
        .fwd_sel1   (fwd_sel1),
        .fwd_sel2   (fwd_sel2),
`endif
        .stall_cnt  (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one decode-stage input vector.
    task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic s2u, input logic [4:0] d, input logic wb,
                         input logic ld, input logic br);
        id_valid    = v;
        src1        = s1;
        src2        = s2;
        src2_used   = s2u;
        id_dest     = d;
        id_wb_en    = wb;
        id_mem_r_en = ld;
        br_taken    = br;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic s, input logic b, input logic f);
        check({tag, "_stall"},  {31'd0, stall},  {31'd0, s});
        check({tag, "_bubble"}, {31'd0, bubble}, {31'd0, b});
        check({tag, "_flush"},  {31'd0, flush},  {31'd0, f});
    endtask

    initial begin
        // Reset held two cycles with br_taken high: all outputs quiet.
        rst = 1'b1;
        drive(1'b1, 5'd3, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
        #1;
        sample(); check_ctl("rst0", 1'b0, 1'b0, 1'b0); check("rst0_cnt", 32'(stall_cnt), 32'd0);
        next_cycle();
        sample(); check_ctl("rst1", 1'b0, 1'b0, 1'b0);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        sample(); check_ctl("post_rst_run", 1'b0, 1'b0, 1'b0); check("post_rst_cnt", 32'(stall_cnt), 32'd0);
        next_cycle();

`ifdef HAZARD_FORWARDING_EN
        // LW r4 then ADD src1=4: one load-use stall, then forward from MEM.
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
        sample(); check_ctl("lw_issue", 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        sample(); check_ctl("lu_stall", 1'b1, 1'b1, 1'b0);
        next_cycle();
        sample(); check_ctl("lu_go", 1'b0, 1'b0, 1'b0); check("lu_fwd1", 32'(fwd_sel1), 32'd2);
        next_cycle();
        // ADD r6 then OR src2=6: no stall, forward from EXE.
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        sample(); check_ctl("add6", 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        sample(); check_ctl("or_go", 1'b0, 1'b0, 1'b0);
        check("or_fwd2", 32'(fwd_sel2), 32'd1); check("or_fwd1", 32'(fwd_sel1), 32'd0);
        check("fwd_cnt", 32'(stall_cnt), 32'd1);
        next_cycle();
`else
        // ADD r3 then SUB src1=3: two stall cycles, WB slot is bypassed.
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        sample(); check_ctl("add3", 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd3, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        sample(); check_ctl("raw_exe", 1'b1, 1'b1, 1'b0);
        next_cycle();
        sample(); check_ctl("raw_mem", 1'b1, 1'b1, 1'b0);
        next_cycle();
        sample(); check_ctl("raw_wb", 1'b0, 1'b0, 1'b0); check("raw_cnt", 32'(stall_cnt), 32'd2);
        next_cycle();
        // r0 producer / r0 consumer: no hazard.
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        sample(); check_ctl("r0_prod", 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        sample(); check_ctl("r0_cons", 1'b0, 1'b0, 1'b0);
        next_cycle();
        // Producer r5; immediate-form consumer ignores src2.
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        sample(); check_ctl("r5_prod", 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        sample(); check_ctl("imm_cons", 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        sample(); check_ctl("src2_cons", 1'b1, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        sample(); check_ctl("invalid_cons", 1'b0, 1'b0, 1'b0); check("src2_cnt", 32'(stall_cnt), 32'd3);
        next_cycle();
        next_cycle();
        // Branch while a consumer is stalled: flush wins, stalled SUB never issues.
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        sample(); check_ctl("br_prod", 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd3, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        sample(); check_ctl("br_stalled", 1'b1, 1'b1, 1'b0);
        next_cycle();
        drive(1'b1, 5'd3, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1);
        sample(); check_ctl("br_taken", 1'b0, 1'b1, 1'b1);
        next_cycle();
        drive(1'b1, 5'd3, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        sample(); check_ctl("br_flush2", 1'b0, 1'b1, 1'b1);
        next_cycle();
        drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        sample(); check_ctl("br_after", 1'b0, 1'b0, 1'b0); check("br_cnt", 32'(stall_cnt), 32'd4);
        next_cycle();
`endif

        // Back-to-back branches: flush cycles 0..2, RUN at cycle 3.
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        sample(); check_ctl("rb0", 1'b0, 1'b1, 1'b1);
        next_cycle();
        sample(); check_ctl("rb1", 1'b0, 1'b1, 1'b1);
        next_cycle();
        br_taken = 1'b0;
        sample(); check_ctl("rb2", 1'b0, 1'b1, 1'b1);
        next_cycle();
        sample(); check_ctl("rb3", 1'b0, 1'b0, 1'b0);
        next_cycle();

        // Reset during a load-use stall clears the scoreboard and the counter.
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
        next_cycle();
        drive(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        sample(); check_ctl("rs_stall", 1'b1, 1'b1, 1'b0);
        next_cycle();
        rst = 1'b1;
        sample(); check_ctl("rs_in_rst", 1'b0, 1'b0, 1'b0);
        next_cycle();
        rst = 1'b0;
        sample(); check_ctl("rs_clean", 1'b0, 1'b0, 1'b0); check("rs_cnt", 32'(stall_cnt), 32'd0);
        next_cycle();

        // Reset during a flush window returns straight to RUN.
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        sample(); check_ctl("rf_br", 1'b0, 1'b1, 1'b1);
        next_cycle();
        rst = 1'b1;
        br_taken = 1'b0;
        sample(); check_ctl("rf_in_rst", 1'b0, 1'b0, 1'b0);
        next_cycle();
        rst = 1'b0;
        sample(); check_ctl("rf_clean", 1'b0, 1'b0, 1'b0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
